// File: rtl/mul_div_if.sv
// Handshake and result bus between the ALU and the iterative multiply/divide unit.
interface mul_div_if #(
  parameter int n = 32
);
  logic         start;
  logic [1:0]   op;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [n-1:0] Hi;
  logic [n-1:0] Lo;

  modport master (output start, op, A, B,
                  input  busy, done, div_by_zero, Hi, Lo);
  modport slave  (input  start, op, A, B,
                  output busy, done, div_by_zero, Hi, Lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the Hi/Lo register pair.
// Shift-add multiply and restoring divide share one 2n-bit work register
// and one n-bit operand register; signs are handled as magnitude + fixup.
module mul_div_unit #(
  parameter int n = 32
) (
  input  logic     clk,
  input  logic     rst,
  mul_div_if.slave bus
);
  localparam int CW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [2*n-1:0] prod;     // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [n-1:0]   opr;      // mult: multiplicand magnitude; div: divisor magnitude
  logic           is_div, is_sgn, sa, sb;
  logic [n-1:0]   hi_r, lo_r;
  logic           dbz_r;

  logic           accept, zero_div, last;
  logic [n:0]     msum;
  logic [n:0]     dshift;
  logic [n+1:0]   dsub;
  logic [2*n-1:0] prod_fx;
  logic [n-1:0]   quo_fx, rem_fx;

  // Magnitude of a two's-complement operand when signed, raw value otherwise.
  function automatic logic [n-1:0] mag(input logic [n-1:0] x, input logic sgn);
    return (sgn && x[n-1]) ? (n'(0) - x) : x;
  endfunction

  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign zero_div = accept && bus.op[1] && (bus.B == '0);
  assign last     = (cnt == CW'(n - 1));

  assign bus.busy        = (state == CALC) || (state == SIGN);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz_r;
  assign bus.Hi          = hi_r;
  assign bus.Lo          = lo_r;

  // One iteration step for both algorithms plus the final sign fixups.
  always_comb begin
    msum    = {1'b0, prod[2*n-1:n]} + {1'b0, (prod[0] ? opr : '0)};
    dshift  = {prod[2*n-1:n], prod[n-1]};
    dsub    = {1'b0, dshift} - {2'b0, opr};
    prod_fx = (is_sgn && (sa ^ sb)) ? ((2*n)'(0) - prod) : prod;
    quo_fx  = (is_sgn && (sa ^ sb)) ? (n'(0) - prod[n-1:0]) : prod[n-1:0];
    rem_fx  = (is_sgn && sa) ? (n'(0) - prod[2*n-1:n]) : prod[2*n-1:n];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: divide-by-zero short-circuits straight to DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (zero_div)    state_nx = DONE;
        else if (accept) state_nx = CALC;
        else             state_nx = IDLE;
      end
      CALC:    if (last) state_nx = SIGN;
      SIGN:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and Hi/Lo write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      prod   <= '0;
      opr    <= '0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      dbz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            is_div <= bus.op[1];
            is_sgn <= bus.op[0];
            sa     <= bus.A[n-1];
            sb     <= bus.B[n-1];
            cnt    <= '0;
            dbz_r  <= zero_div;
            if (zero_div) begin
              hi_r <= bus.A;
              lo_r <= '1;
            end else if (bus.op[1]) begin
              prod <= {{n{1'b0}}, mag(bus.A, bus.op[0])};
              opr  <= mag(bus.B, bus.op[0]);
            end else begin
              prod <= {{n{1'b0}}, mag(bus.B, bus.op[0])};
              opr  <= mag(bus.A, bus.op[0]);
            end
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            if (!dsub[n+1]) prod <= {dsub[n-1:0], prod[n-2:0], 1'b1};
            else            prod <= {dshift[n-1:0], prod[n-2:0], 1'b0};
          end else begin
            prod <= {msum, prod[n-1:1]};
          end
        end
        SIGN: begin
          if (is_div) begin
            hi_r <= rem_fx;
            lo_r <= quo_fx;
          end else begin
            hi_r <= prod_fx[2*n-1:n];
            lo_r <= prod_fx[n-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver pushes expected Hi/Lo/flag
// from an arithmetic reference model; a monitor pops and compares on done.
module tb_mul_div_unit;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_div_if #(.n(N)) m();
  mul_div_unit #(.n(N)) dut (.clk(clk), .rst(rst), .bus(m));

  typedef struct packed {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic; signed / and % truncate toward zero.
  function automatic exp_t model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t        e;
    logic [63:0] up;
    longint      sa, sb, sp, q, r;
    sa = $signed(a);
    sb = $signed(b);
    e.dbz = 1'b0;
    case (op)
      2'b00: begin up = {32'b0, a} * {32'b0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
      2'b01: begin sp = sa * sb; e.hi = sp[63:32]; e.lo = sp[31:0]; end
      default: begin
        if (b == 0) begin
          e.hi = a; e.lo = '1; e.dbz = 1'b1;
        end else if (op == 2'b10) begin
          e.hi = a % b; e.lo = a / b;
        end else begin
          q = sa / sb; r = sa % sb;
          e.hi = r[31:0]; e.lo = q[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && m.done) begin
      exp_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        check("done with empty queue", 64'(m.done), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("Hi", 64'(m.Hi), 64'(e.hi));
        check("Lo", 64'(m.Lo), 64'(e.lo));
        check("div_by_zero", 64'(m.div_by_zero), 64'(e.dbz));
        check("busy at done", 64'(m.busy), 64'(0));
      end
    end
  end

  // Issue one accepted op at a negedge; scrambles A/B/op once start drops.
  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    m.start = 1'b1; m.op = o; m.A = a; m.B = b;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    m.start = 1'b0;
    m.A = $urandom; m.B = $urandom; m.op = 2'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!m.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!m.done) check("done timeout", 64'(cyc), 64'(0));
  endtask

  task automatic wait_free();
    int k = 0;
    while (m.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (m.busy) check("busy timeout", 64'(k), 64'(0));
  endtask

  initial begin
    int cyc, busy_cnt, done_cnt, done_at, d0;
    logic [N-1:0] a, b;
    logic [1:0]   o;
    m.start = 1'b0; m.op = 2'b00; m.A = '0; m.B = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset Hi", 64'(m.Hi), 64'(0));
    check("reset Lo", 64'(m.Lo), 64'(0));
    check("reset busy", 64'(m.busy), 64'(0));
    check("reset done", 64'(m.done), 64'(0));
    check("reset dbz", 64'(m.div_by_zero), 64'(0));

    // MULTU max*max with latency profile
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (m.busy) busy_cnt++;
      if (m.done) begin
        done_cnt++;
        done_at = c;
        check("multu Hi const", 64'(m.Hi), 64'h0000_0000_FFFF_FFFE);
        check("multu Lo const", 64'(m.Lo), 64'h0000_0000_0000_0001);
      end
      @(negedge clk);
    end
    check("busy cycles", 64'(busy_cnt), 64'(33));
    check("done pulses", 64'(done_cnt), 64'(1));
    check("done latency", 64'(done_at), 64'(34));

    // Signed / unsigned small cases
    issue(2'b01, 32'hFFFF_FFF9, 32'd6);  wait_done(cyc);
    check("mult Lo const", 64'(m.Lo), 64'h0000_0000_FFFF_FFD6);
    @(negedge clk);
    issue(2'b11, 32'hFFFF_FFE9, 32'd5);  wait_done(cyc);
    check("div Lo const", 64'(m.Lo), 64'h0000_0000_FFFF_FFFC);
    check("div Hi const", 64'(m.Hi), 64'h0000_0000_FFFF_FFFD);
    @(negedge clk);
    issue(2'b10, 32'd23, 32'd5);         wait_done(cyc);
    @(negedge clk);

    // Divide by zero: done on the very next cycle, flag clears on next start
    issue(2'b10, 32'd23, 32'd0);
    wait_done(cyc);
    check("dbz latency", 64'(cyc), 64'(0));
    check("dbz flag", 64'(m.div_by_zero), 64'(1));
    @(negedge clk);
    issue(2'b00, 32'd2, 32'd3);
    check("dbz cleared", 64'(m.div_by_zero), 64'(0));
    wait_done(cyc);
    @(negedge clk);

    // Start while busy is ignored; start in DONE is accepted back-to-back
    issue(2'b00, 32'd10, 32'd3);
    repeat (3) @(negedge clk);
    m.start = 1'b1; m.op = 2'b10; m.A = 32'd100; m.B = 32'd7;
    @(negedge clk);
    m.start = 1'b0;
    wait_done(cyc);
    check("ignored start Lo", 64'(m.Lo), 64'(30));
    issue(2'b00, 32'd5, 32'd5);
    check("Hi held while busy", 64'(m.Hi), 64'(0));
    check("Lo held while busy", 64'(m.Lo), 64'(30));
    wait_done(cyc);
    check("back-to-back latency", 64'(cyc + 1), 64'(34));
    @(negedge clk);

    // Reset mid-operation aborts without writing Hi/Lo
    issue(2'b10, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort busy", 64'(m.busy), 64'(0));
    check("abort done", 64'(m.done), 64'(0));
    check("abort Hi", 64'(m.Hi), 64'(0));
    check("abort Lo", 64'(m.Lo), 64'(0));
    rst = 1'b0;
    d0 = done_seen;
    repeat (40) @(negedge clk);
    check("no done after abort", 64'(done_seen - d0), 64'(0));

    // Most-negative corner cases
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(cyc);
    check("div minneg Lo const", 64'(m.Lo), 64'h0000_0000_8000_0000);
    @(negedge clk);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000); wait_done(cyc);
    check("mult minneg Hi const", 64'(m.Hi), 64'h0000_0000_4000_0000);
    @(negedge clk);

    // Randomized ops, with scrambled inputs during CALC and random gaps
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      wait_free();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(o, a, b);
    end
    wait_free();
    repeat (3) @(negedge clk);
    check("queue drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit that owns the architectural Hi/Lo register pair.
- The single-cycle ALU hands off MULT/MULTU/DIV/DIVU operations to this block.
- Started with a one-cycle pulse; reports busy/done; holds the result in Hi/Lo until the next operation completes.
- Lets the datapath keep a short critical path and stall only on Hi/Lo consumers.

Parameters:
- n, 32: operand width; Hi and Lo are each n bits; iteration count is n.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only when busy=0
- op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
- A  input  n  multiplicand / dividend
- B  input  n  multiplier / divisor
- busy  output  1  operation in progress; new start ignored
- done  output  1  one-cycle pulse: Hi/Lo just updated
- div_by_zero  output  1  sticky flag for last op; valid while done=1 and until next start
- Hi  output  n  product upper half / remainder
- Lo  output  n  product lower half / quotient

Behaviour:
- Reset:
  - Synchronous and active-high; clk and rst are the only clock and reset.
  - On a clk edge with rst=1: state=IDLE; busy=0, done=0, div_by_zero=0, Hi=0, Lo=0; internal counter and accumulators cleared.
  - rst mid-operation aborts; no partial result reaches Hi/Lo.
- State machine: IDLE, CALC, SIGN, DONE.
- IDLE / DONE:
  - busy=0. done=1 only in DONE.
  - start=1 accepted in either state, so back-to-back ops are possible.
  - On accept:
    - Latch op and the sign of A and B.
    - Store |A| and |B| for signed ops, raw values for unsigned.
    - Clear div_by_zero and counter; go to CALC.
  - Division with B=0: go directly to DONE. Hi=A, Lo={n{1'b1}}, div_by_zero=1; the signed/unsigned result is the same.
  - DONE without a new start returns to IDLE after one cycle.
- CALC (busy=1):
  - One iteration per clk; the counter runs 0..n-1. Enter SIGN on the edge where counter=n-1.
  - Multiply: shift-add on a 2n-bit product register.
  - Divide: restoring division; n-bit remainder plus a 1-bit subtract borrow.
- SIGN (busy=1), one cycle:
  - Apply sign fixup, write Hi/Lo, go to DONE.
  - MULT: negate the 2n-bit product if sign(A)^sign(B).
  - DIV: negate the quotient if sign(A)^sign(B). Negate the remainder if sign(A); the remainder takes the dividend's sign and the quotient truncates toward zero.
  - Unsigned ops: no fixup.
- Latency: start sampled at edge 0 gives CALC on edges 1..n, Hi/Lo written at edge n+1, done=1 in the following cycle. For n=32, 34 cycles from start to done.
- Hi/Lo hold their values at all other times, including while busy; they are readable while a new op runs.
- Boundary cases:
  - start while busy=1: ignored; no restart, no error.
  - start held high for several cycles: accepted once per entry into IDLE/DONE.
  - DIV -2^(n-1) / -1: Lo=2^(n-1) (wraps to most-negative), Hi=0, no flag.
  - MULT -2^(n-1) * -2^(n-1): {Hi,Lo}=2^(2n-2).
  - A or B changing during CALC: no effect; operands are latched.
  - op changing during CALC: no effect.

Test Plan:
- rst=1 for 2 cycles, then idle -> Hi=0, Lo=0, busy=0, done=0, div_by_zero=0.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. busy=1 for 33 cycles; done pulses exactly once, 34 cycles after start.
- MULT A=-7 (0xFFFFFFF9), B=6 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFD6 (-42). Then DIV A=-23, B=5 -> Lo=-4 (0xFFFFFFFC), Hi=-3 (0xFFFFFFFD). DIVU A=23, B=5 -> Lo=4, Hi=3.
- DIVU A=23, B=0 -> done the cycle after start, Hi=23, Lo=0xFFFFFFFF, div_by_zero=1. The next valid start clears div_by_zero.
- Start MULTU 10*3; pulse start with op=DIVU at cycle 5 -> second start ignored, Hi=0, Lo=30. Start issued in the DONE cycle -> accepted, and the next result follows 34 cycles later.
- Start DIVU 100/7; assert rst at cycle 10 -> the next cycle shows IDLE, busy=0, Hi=Lo=0, and done never pulses. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
